// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - SECDED sizing helpers, codeword layout and golden encoder
package secded_pkg;

   typedef enum logic [1:0] {CLEAN, SINGLE, DOUBLE} err_class_e;

   // Smallest P with 2^P >= data_w + P + 1.
   function automatic int par_w(input int data_w);
      int p;
      p = 0;
      for (int k = 1; k <= 16; k++) begin
         if (p == 0 && (1 << k) >= data_w + k + 1) p = k;
      end
      return p;
   endfunction

   function automatic int cw_w(input int data_w);
      return data_w + par_w(data_w) + 1;
   endfunction

   // Data bits fill the non-power-of-two positions from 3 upward, bit 0 first.
   function automatic int data_pos(input int i);
      int pos;
      int cnt;
      pos = 0;
      cnt = 0;
      for (int p = 3; p < 512; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == i && pos == 0) pos = p;
            cnt++;
         end
      end
      return pos;
   endfunction

   localparam int DATA_MAX = 256;
   localparam int CW_MAX   = cw_w(DATA_MAX);

   // Reference encoder: Hamming parity at 2^k, overall parity in bit 0.
   function automatic logic [CW_MAX-1:0] encode(input logic [DATA_MAX-1:0] data,
                                                input int data_w);
      logic [CW_MAX-1:0] cw;
      int                syn;
      cw  = '0;
      syn = 0;
      for (int i = 0; i < data_w; i++) begin
         cw[data_pos(i)] = data[i];
         if (data[i]) syn ^= data_pos(i);
      end
      for (int k = 0; k < par_w(data_w); k++) cw[1 << k] = syn[k];
      cw[0] = ^cw;
      return cw;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// rtl/secded_syndrome.sv - combinational Hamming syndrome and overall parity check
module secded_syndrome
   import secded_pkg::*;
#(
   parameter int  DATA_W = 64,
   localparam int PAR_W  = par_w(DATA_W),
   localparam int CW_W   = cw_w(DATA_W)
)(
   input  logic [CW_W-1:0]  cw,
   output logic [PAR_W-1:0] syn,
   output logic             par_mis
);

   // Syndrome is the XOR of the positions of all set bits; bit 0 only feeds parity.
   always_comb begin
      syn = '0;
      for (int p = 1; p < CW_W; p++) begin
         if (cw[p]) syn ^= p[PAR_W-1:0];
      end
      par_mis = ^cw;
   end

endmodule

// File: rtl/secded_decoder_pipe.sv
// rtl/secded_decoder_pipe.sv - two-stage SECDED decoder with handshakes, counters and error log
module secded_decoder_pipe
   import secded_pkg::*;
#(
   parameter int  DATA_W     = 64,
   parameter int  TAG_W      = 8,
   parameter int  CNT_W      = 16,
   parameter int  CORRECT_EN = 1,
   localparam int PAR_W      = par_w(DATA_W),
   localparam int CW_W       = cw_w(DATA_W)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   e_data,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] d_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              err,
   output logic              s_err,
   output logic              d_err,
   output logic [PAR_W-1:0]  syndrome,
   output logic [CNT_W-1:0]  s_cnt,
   output logic [CNT_W-1:0]  d_cnt,
   input  logic              cnt_clr,
   output logic              log_valid,
   output logic [TAG_W-1:0]  log_tag,
   output logic [PAR_W-1:0]  log_syn,
   output logic              log_derr,
   input  logic              log_clr
);

   localparam logic [PAR_W:0]   CW_LIM  = (PAR_W + 1)'(CW_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              en;
   logic              hs;
   logic [PAR_W-1:0]  in_syn;
   logic              in_pm;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] hit;
   logic [DATA_W-1:0] fix_data;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [TAG_W-1:0]  s1_tag;
   logic [PAR_W-1:0]  s1_syn;
   logic              s1_pm;

   err_class_e        cls;
   logic              flip;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign hs       = out_valid && out_ready;
   assign err      = s_err || d_err;

   secded_syndrome #(.DATA_W(DATA_W)) u_syn (
      .cw      (e_data),
      .syn     (in_syn),
      .par_mis (in_pm)
   );

   // Only data bits are kept past stage 1; hit[i] marks the data bit the syndrome points at.
   for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      localparam int POS = data_pos(i);
      assign in_data[i] = e_data[POS];
      assign hit[i]     = (s1_syn == PAR_W'(POS));
   end

   // Stage 1: capture raw data, tag, syndrome and parity mismatch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_tag   <= '0;
         s1_syn   <= '0;
         s1_pm    <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_tag  <= in_tag;
            s1_syn  <= in_syn;
            s1_pm   <= in_pm;
         end
      end
   end

   // Classify the stage-1 word and decide whether a data bit gets flipped.
   always_comb begin
      cls  = CLEAN;
      flip = 1'b0;
      if (s1_syn == '0) begin
         if (s1_pm) cls = SINGLE;
      end else if (s1_pm && ({1'b0, s1_syn} < CW_LIM)) begin
         cls  = SINGLE;
         flip = (CORRECT_EN != 0);
      end else begin
         cls = DOUBLE;
      end
      fix_data = s1_data ^ (flip ? hit : '0);
   end

   // Stage 2: register the decoded result and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         d_data    <= '0;
         out_tag   <= '0;
         s_err     <= 1'b0;
         d_err     <= 1'b0;
         syndrome  <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            d_data   <= fix_data;
            out_tag  <= s1_tag;
            s_err    <= (cls == SINGLE);
            d_err    <= (cls == DOUBLE);
            syndrome <= s1_syn;
         end
      end
   end

   // Saturating error counters, bumped on output handshake; clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_cnt <= '0;
         d_cnt <= '0;
      end else if (cnt_clr) begin
         s_cnt <= '0;
         d_cnt <= '0;
      end else if (hs) begin
         if (s_err && s_cnt != CNT_MAX) s_cnt <= s_cnt + 1'b1;
         if (d_err && d_cnt != CNT_MAX) d_cnt <= d_cnt + 1'b1;
      end
   end

   // First-error log; a clear in the same cycle as an erroring handshake re-arms and captures.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         log_valid <= 1'b0;
         log_tag   <= '0;
         log_syn   <= '0;
         log_derr  <= 1'b0;
      end else if (hs && err && (!log_valid || log_clr)) begin
         log_valid <= 1'b1;
         log_tag   <= out_tag;
         log_syn   <= syndrome;
         log_derr  <= d_err;
      end else if (log_clr) begin
         log_valid <= 1'b0;
         log_tag   <= '0;
         log_syn   <= '0;
         log_derr  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// tb/tb_secded_decoder_pipe.sv - scoreboard bench for secded_decoder_pipe
module tb_secded_decoder_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [71:0] e_data;
   logic [7:0]  in_tag;
   logic        out_ready;
   logic        cnt_clr;
   logic        log_clr;

   logic        in_ready, out_valid, err, s_err, d_err, log_valid, log_derr;
   logic [63:0] d_data;
   logic [7:0]  out_tag, log_tag;
   logic [6:0]  syndrome, log_syn;
   logic [1:0]  s_cnt, d_cnt;

   logic        nc_in_ready, nc_out_valid, nc_err, nc_s_err, nc_d_err, nc_log_valid, nc_log_derr;
   logic [63:0] nc_d_data;
   logic [7:0]  nc_out_tag, nc_log_tag;
   logic [6:0]  nc_syndrome, nc_log_syn;
   logic [15:0] nc_s_cnt, nc_d_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] data;
      logic [63:0] nc_data;
      logic [7:0]  tag;
      logic        s;
      logic        d;
      logic [6:0]  syn;
   } exp_t;

   exp_t sb[$];

   secded_decoder_pipe #(.DATA_W(64), .TAG_W(8), .CNT_W(2), .CORRECT_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .e_data(e_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .d_data(d_data), .out_tag(out_tag), .err(err), .s_err(s_err), .d_err(d_err),
      .syndrome(syndrome), .s_cnt(s_cnt), .d_cnt(d_cnt), .cnt_clr(cnt_clr),
      .log_valid(log_valid), .log_tag(log_tag), .log_syn(log_syn),
      .log_derr(log_derr), .log_clr(log_clr)
   );

   secded_decoder_pipe #(.DATA_W(64), .TAG_W(8), .CNT_W(16), .CORRECT_EN(0)) dut_nc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready),
      .e_data(e_data), .in_tag(in_tag), .out_valid(nc_out_valid), .out_ready(out_ready),
      .d_data(nc_d_data), .out_tag(nc_out_tag), .err(nc_err), .s_err(nc_s_err), .d_err(nc_d_err),
      .syndrome(nc_syndrome), .s_cnt(nc_s_cnt), .d_cnt(nc_d_cnt), .cnt_clr(cnt_clr),
      .log_valid(nc_log_valid), .log_tag(nc_log_tag), .log_syn(nc_log_syn),
      .log_derr(nc_log_derr), .log_clr(log_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Walk positions 1..71, skipping powers of two, to pull out the 64 data bits.
   function automatic logic [63:0] extract(input logic [71:0] cw);
      logic [63:0] ext;
      int          k;
      ext = '0;
      k   = 0;
      for (int p = 1; p < 72; p++) begin
         if ((p & (p - 1)) != 0) begin
            ext[k] = cw[p];
            k++;
         end
      end
      return ext;
   endfunction

   task automatic send(input logic [63:0] data, input logic [7:0] tag,
                       input int b0, input int b1, input int b2,
                       input logic es, input logic ed, input logic [6:0] esyn);
      logic [secded_pkg::CW_MAX-1:0] full;
      logic [71:0] cw;
      exp_t        e;
      logic        rdy;
      int          n;
      full = secded_pkg::encode({192'd0, data}, 64);
      cw   = full[71:0];
      if (b0 >= 0) cw[b0] = ~cw[b0];
      if (b1 >= 0) cw[b1] = ~cw[b1];
      if (b2 >= 0) cw[b2] = ~cw[b2];
      e.data    = ed ? extract(cw) : data;
      e.nc_data = extract(cw);
      e.tag     = tag;
      e.s       = es;
      e.d       = ed;
      e.syn     = esyn;
      sb.push_back(e);
      in_valid = 1'b1;
      e_data   = cw;
      in_tag   = tag;
      n   = 0;
      rdy = 1'b0;
      while (!rdy && n < 100) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         n++;
      end
      if (!rdy) chk("accept_timeout", 1'b0, 1'b1);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_lat(input logic [63:0] data, input logic [7:0] tag,
                           input int b0, input logic es, input logic [6:0] esyn);
      send(data, tag, b0, -1, -1, es, 1'b0, esyn);
      chk("lat_not_early", out_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("lat_valid", out_valid, 1'b1);
      chk("lat_tag", out_tag, tag);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("drain_empty", sb.size() == 0, 1'b1);
      @(posedge clk);
      #1;
   endtask

   // Compare every output handshake against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("d_data", d_data, e.data);
            chk("out_tag", out_tag, e.tag);
            chk("s_err", s_err, e.s);
            chk("d_err", d_err, e.d);
            chk("err", err, e.s | e.d);
            chk("syndrome", syndrome, e.syn);
            chk("nc_valid", nc_out_valid, 1'b1);
            chk("nc_d_data", nc_d_data, e.nc_data);
            chk("nc_s_err", nc_s_err, e.s);
            chk("nc_d_err", nc_d_err, e.d);
         end
      end
   end

   initial begin
      logic [63:0] snap_d;
      logic [7:0]  snap_t;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      e_data    = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      log_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_d_data", d_data, 64'd0);
      chk("rst_syndrome", syndrome, 7'd0);
      chk("rst_s_cnt", s_cnt, 2'd0);
      chk("rst_log_valid", log_valid, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);

      // clean stream
      send_lat(64'hDEAD_BEEF_CAFE_CAFE, 8'd1, -1, 1'b0, 7'd0);
      send_lat(64'hCAFE_CAFE_DEAD_BEEF, 8'd2, -1, 1'b0, 7'd0);
      send_lat(64'h1212_3434_5656_7878, 8'd3, -1, 1'b0, 7'd0);
      drain();
      chk("clean_s_cnt", s_cnt, 2'd0);
      chk("clean_d_cnt", d_cnt, 2'd0);
      chk("clean_log", log_valid, 1'b0);

      // single errors
      send(64'hDEAD_BEEF_CAFE_CAFE, 8'd4, 20, -1, -1, 1'b1, 1'b0, 7'd20);
      drain();
      chk("se_s_cnt", s_cnt, 2'd1);
      chk("se_log_valid", log_valid, 1'b1);
      chk("se_log_syn", log_syn, 7'd20);
      chk("se_log_tag", log_tag, 8'd4);
      chk("se_log_derr", log_derr, 1'b0);
      send(64'hDEAD_BEEF_CAFE_CAFE, 8'd5, 0, -1, -1, 1'b1, 1'b0, 7'd0);
      drain();
      chk("b0_s_cnt", s_cnt, 2'd2);

      // double errors and log behaviour
      send(64'hDEAD_BEEF_CAFE_CAFE, 8'd6, 40, 44, -1, 1'b0, 1'b1, 7'd4);
      drain();
      chk("de_d_cnt", d_cnt, 2'd1);
      chk("de_s_cnt", s_cnt, 2'd2);
      chk("de_log_keep_tag", log_tag, 8'd4);
      chk("de_log_keep_derr", log_derr, 1'b0);
      log_clr = 1'b1;
      @(posedge clk);
      #1;
      log_clr = 1'b0;
      chk("logclr_valid", log_valid, 1'b0);
      send(64'h0123_4567_89AB_CDEF, 8'd7, 3, 5, -1, 1'b0, 1'b1, 7'd6);
      drain();
      chk("de2_log_valid", log_valid, 1'b1);
      chk("de2_log_derr", log_derr, 1'b1);
      chk("de2_log_tag", log_tag, 8'd7);
      chk("de2_log_syn", log_syn, 7'd6);
      chk("de2_d_cnt", d_cnt, 2'd2);
      // three parity-bit flips: syndrome 73 lies beyond the codeword
      send(64'h5555_AAAA_0F0F_F0F0, 8'd8, 1, 8, 64, 1'b0, 1'b1, 7'd73);
      drain();
      chk("oob_d_cnt", d_cnt, 2'd3);
      chk("oob_log_tag", log_tag, 8'd7);

      // backpressure
      fork
         begin
            send(64'h1111_1111_1111_1111, 8'd10, -1, -1, -1, 1'b0, 1'b0, 7'd0);
            send(64'h2222_2222_2222_2222, 8'd11, -1, -1, -1, 1'b0, 1'b0, 7'd0);
            send(64'h3333_3333_3333_3333, 8'd12, -1, -1, -1, 1'b0, 1'b0, 7'd0);
            send(64'h4444_4444_4444_4444, 8'd13, -1, -1, -1, 1'b0, 1'b0, 7'd0);
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            snap_d = d_data;
            snap_t = out_tag;
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_first_tag", out_tag, 8'd10);
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               chk("bp_in_ready", in_ready, 1'b0);
               chk("bp_stable_d", d_data, snap_d);
               chk("bp_stable_tag", out_tag, snap_t);
               chk("bp_stable_valid", out_valid, 1'b1);
               @(posedge clk);
            end
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // saturation and clear priority
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      chk("cclr_s_cnt", s_cnt, 2'd0);
      chk("cclr_d_cnt", d_cnt, 2'd0);
      send(64'hAAAA_0000_FFFF_1234, 8'd20, 1, -1, -1, 1'b1, 1'b0, 7'd1);
      send(64'hAAAA_0000_FFFF_1234, 8'd21, 2, -1, -1, 1'b1, 1'b0, 7'd2);
      send(64'hAAAA_0000_FFFF_1234, 8'd22, 33, -1, -1, 1'b1, 1'b0, 7'd33);
      send(64'hAAAA_0000_FFFF_1234, 8'd23, 50, -1, -1, 1'b1, 1'b0, 7'd50);
      send(64'hAAAA_0000_FFFF_1234, 8'd24, 71, -1, -1, 1'b1, 1'b0, 7'd71);
      drain();
      chk("sat_s_cnt", s_cnt, 2'd3);
      send(64'hAAAA_0000_FFFF_1234, 8'd25, 12, -1, -1, 1'b1, 1'b0, 7'd12);
      @(posedge clk);
      #1;
      cnt_clr = 1'b1;
      log_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      log_clr = 1'b0;
      chk("clrwin_s_cnt", s_cnt, 2'd0);
      chk("clrcap_log_valid", log_valid, 1'b1);
      chk("clrcap_log_tag", log_tag, 8'd25);
      chk("clrcap_log_syn", log_syn, 7'd12);
      chk("clrcap_log_derr", log_derr, 1'b0);
      send(64'h0F0F_0F0F_0F0F_0F0F, 8'd29, 7, -1, -1, 1'b1, 1'b0, 7'd7);
      drain();
      chk("pre_rst_s_cnt", s_cnt, 2'd1);

      // reset with two words in flight
      send(64'h9999_8888_7777_6666, 8'd30, -1, -1, -1, 1'b0, 1'b0, 7'd0);
      send(64'h6666_7777_8888_9999, 8'd31, -1, -1, -1, 1'b0, 1'b0, 7'd0);
      chk("inflight_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_s_cnt", s_cnt, 2'd0);
      chk("mrst_log_valid", log_valid, 1'b0);
      chk("mrst_log_tag", log_tag, 8'd0);
      chk("mrst_out_tag", out_tag, 8'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_in_ready", in_ready, 1'b1);
      chk("mrst_no_partial1", out_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("mrst_no_partial2", out_valid, 1'b0);
      send_lat(64'hFEED_FACE_0BAD_F00D, 8'd32, -1, 1'b0, 7'd0);
      drain();
      chk("end_s_cnt", s_cnt, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/secded_decoder_pipe.md
Name: secded_decoder_pipe

Overview:
- Parametrised, two-stage pipelined SECDED decoder with valid/ready handshakes on input and output.
- Successor to the fixed 64/72 single-cycle decoder. Sits between ECC-protected storage read data and the consumer.
- Adds four things the fixed decoder lacks: configurable data width, backpressure, saturating error counters and a first-error log.
- A tag travels with each word so the consumer can match responses to requests.

Parameters:
- DATA_W, 64, data bits per word, 8..256.
- PAR_W, derived, Hamming parity bits: smallest P with 2^P >= DATA_W+P+1 (7 for 64). Not overridable.
- CW_W, derived, codeword width = DATA_W+PAR_W+1 (72 for 64).
- TAG_W, 8, width of the sideband tag carried alongside each word.
- CNT_W, 16, width of the saturating error counters.
- CORRECT_EN, 1, 1 = correct single errors; 0 = detect/flag only, data passes uncorrected.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  codeword offered.
- IN_READY  out  1  decoder accepts this cycle.
- E_DATA  in  CW_W  received codeword, possibly corrupted.
- IN_TAG  in  TAG_W  sideband tag.
- OUT_VALID  out  1  decoded result valid.
- OUT_READY  in  1  consumer accepts.
- D_DATA  out  DATA_W  decoded data (corrected if CORRECT_EN=1).
- OUT_TAG  out  TAG_W  tag of the word on D_DATA.
- ERR  out  1  S_ERR | D_ERR.
- S_ERR  out  1  single-bit error detected.
- D_ERR  out  1  uncorrectable error.
- SYNDROME  out  PAR_W  Hamming syndrome of the output word.
- S_CNT  out  CNT_W  saturating count of single errors.
- D_CNT  out  CNT_W  saturating count of uncorrectable errors.
- CNT_CLR  in  1  synchronous clear of both counters.
- LOG_VALID  out  1  sticky: an error has been logged.
- LOG_TAG  out  TAG_W  tag of the first logged error.
- LOG_SYN  out  PAR_W  syndrome of the first logged error.
- LOG_DERR  out  1  first logged error was uncorrectable.
- LOG_CLR  in  1  synchronous clear of the log.

Behaviour:
- Codeword layout: bit 0 = overall parity over bits 1..CW_W-1. Bits 1..CW_W-1 form a Hamming code: parity at positions 2^k; data fills the remaining positions in ascending order, data bit 0 first.
- Stage 1: register E_DATA, tag, syndrome (XOR of positions of set bits) and overall-parity mismatch.
- Stage 2: classify, correct, register outputs.
- Latency: exactly 2 cycles from the accept edge to OUT_VALID when unstalled. Throughput 1 word/cycle.
- Advance enable: en = !OUT_VALID || OUT_READY. IN_READY = en, combinational.
- The pipeline holds whole when en=0; stage contents and outputs stay stable while OUT_VALID && !OUT_READY. Bubbles are squeezed out only by en.
- Classification (syn = syndrome, pm = parity mismatch):
  - syn==0, pm==0: clean.
  - syn==0, pm==1: S_ERR; error is in bit 0; data unchanged.
  - syn!=0, pm==1, syn<CW_W: S_ERR; flip codeword bit syn when CORRECT_EN=1.
  - syn!=0, pm==1, syn>=CW_W: D_ERR, no flip.
  - syn!=0, pm==0: D_ERR, no flip.
- D_DATA on D_ERR carries the raw extracted data.
- Counters update only on output handshake (OUT_VALID && OUT_READY):
  - S_CNT increments on S_ERR; D_CNT increments on D_ERR.
  - Both saturate at 2^CNT_W-1.
  - CNT_CLR wins over a same-cycle increment: result 0.
- Log:
  - On a handshake with ERR while LOG_VALID=0, capture tag, syndrome and D_ERR; set LOG_VALID.
  - Later errors are ignored until LOG_CLR.
  - LOG_CLR together with an erroring handshake: clear, then capture. LOG_VALID stays 1 holding the new entry.
- Reset:
  - All valids, counters, log, SYNDROME, flags, D_DATA and OUT_TAG are 0.
  - IN_READY is 1 one cycle after deassertion.
  - In-flight words are discarded, with no partial output.

Decomposition:
- Package secded_pkg holds:
  - function par_w(DATA_W), function cw_w(DATA_W);
  - function encode(data) as the golden model;
  - function data_pos(i), the codeword position of data bit i;
  - enum err_class_e {CLEAN, SINGLE, DOUBLE}.
- One combinational sub-module, secded_syndrome (params DATA_W; outputs syndrome, parity mismatch). It is shared with the encoder-side checker.

Test Plan:
- Clean stream: DEAD_BEEF_CAFE_CAFE, CAFE_CAFE_DEAD_BEEF, 1212_3434_5656_7878 encoded via secded_pkg::encode, OUT_READY=1 -> same data after 2 cycles each, tags 1,2,3 in order, ERR=0, counters 0.
- Single error: flip codeword bit 20 of DEAD_BEEF_CAFE_CAFE -> D_DATA=DEAD_BEEF_CAFE_CAFE, S_ERR=1, SYNDROME=20, S_CNT=1, LOG_VALID=1, LOG_SYN=20. Flip only bit 0 -> S_ERR=1, SYNDROME=0, data exact.
- Double error: flip bits 40 and 44 -> D_ERR=1, S_ERR=0, D_CNT=1. LOG keeps the earlier single-error entry; after LOG_CLR plus a new double error, LOG_DERR=1.
- Backpressure: 4 words in back-to-back, OUT_READY low cycles 3-5 -> IN_READY low while stalled, outputs stable, all 4 delivered in order, none lost or duplicated.
- Saturation and clear with CNT_W=2: 5 single errors -> S_CNT=3. CNT_CLR asserted with a 6th error handshake -> S_CNT=0.
- RST_N pulsed low with 2 words in flight -> OUT_VALID=0 immediately, counters and log 0, next accepted word decodes correctly after 2 cycles. CORRECT_EN=0 build: single error in bit 20 -> S_ERR=1, D_DATA has the flipped bit.
